hazard_fwd_unit: RTL and testbench

- Second-generation hazard/forwarding controller for the 5-stage pipeline.
- Generalises operand forwarding to NUM_SRC sources and REG_AW-bit register addresses, and keeps store-data forwarding from WB into M.
- Adds sequential hazard handling:
  - one-bubble load-use stall;
  - scoreboard for one multi-cycle mul/div unit with a fixed MD_LAT latency, covering RAW and WAW stalls and a deferred writeback slot.
- Sits beside the ID/EX/M/WB pipeline registers and drives their forward muxes and stall/flush controls.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_fwd_unit_if.sv | 49 ++++
 rtl/hazard_fwd_unit_md_scoreboard.sv | 57 +++++
 rtl/hazard_fwd_unit.sv | 91 +++++++++
 tb/tb_hazard_fwd_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hazard_pkg;

    // Forward-mux select encodings driven onto each EX source operand.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Mul/div scoreboard state.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle of register addresses/enables and the forward/stall controls.
// Latency: n/a (wires only).
// Backpressure: n/a; stall/flush_ex are the pipeline's hold signals.
interface hazard_fwd_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_regwr;
    logic                      id_md_op;
    logic [NUM_SRC*REG_AW-1:0] ex_src;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_regwr;
    logic                      ex_memrd;
    logic                      ex_md_start;
    logic [REG_AW-1:0]         m_rd;
    logic                      m_regwr;
    logic                      m_memwr;
    logic [REG_AW-1:0]         m_rb;
    logic [REG_AW-1:0]         wb_rd;
    logic                      wb_regwr;
    logic [NUM_SRC*2-1:0]      ex_fwd_sel;
    logic                      m_store_fwd;
    logic                      stall;
    logic                      flush_ex;
    logic                      md_busy;
    logic [REG_AW-1:0]         md_rd;
    logic                      md_wb_valid;

    // Pipeline register side: supplies addresses, consumes controls.
    modport master (
        output id_src, id_src_used, id_rd, id_regwr, id_md_op,
        output ex_src, ex_rd, ex_regwr, ex_memrd, ex_md_start,
        output m_rd, m_regwr, m_memwr, m_rb, wb_rd, wb_regwr,
        input  ex_fwd_sel, m_store_fwd, stall, flush_ex,
        input  md_busy, md_rd, md_wb_valid
    );

    // Hazard unit side.
    modport slave (
        input  id_src, id_src_used, id_rd, id_regwr, id_md_op,
        input  ex_src, ex_rd, ex_regwr, ex_memrd, ex_md_start,
        input  m_rd, m_regwr, m_memwr, m_rb, wb_rd, wb_regwr,
        output ex_fwd_sel, m_store_fwd, stall, flush_ex,
        output md_busy, md_rd, md_wb_valid
    );
endinterface

// File: rtl/hazard_fwd_unit_md_scoreboard.sv
// Tracks the single outstanding mul/div result and its regfile writeback slot.
// Latency: md_wb_valid first MD_LAT cycles after the issuing edge when WB is free.
// Backpressure: writeback defers (cnt held at 0) while the WB stage writes the regfile.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_md_start,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              wb_regwr,
    output logic              md_busy,
    output logic [REG_AW-1:0] md_rd,
    output logic              md_wb_valid
);
    localparam int CNT_W = $clog2(MD_LAT);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;

    assign md_busy     = (state == MD_BUSY);
    // Result writes only when the countdown is done and the WB write port is free.
    assign md_wb_valid = md_busy && (cnt == '0) && !wb_regwr;

    // Issue capture, countdown, deferred writeback and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            md_rd <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    // A start targeting r0 has no visible result, so nothing to track.
                    if (ex_md_start && (ex_rd != '0)) begin
                        state <= MD_BUSY;
                        md_rd <= ex_rd;
                        cnt   <= CNT_W'(MD_LAT - 1);
                    end
                end
                MD_BUSY: begin
                    // A second start while busy is ignored.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!wb_regwr) begin
                        state <= MD_IDLE;
                        md_rd <= '0;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand/store forwarding plus load-use and mul/div stall generation for the 5-stage pipe.
// Latency: forward selects and stall/flush are combinational; mul/div tracking is registered.
// Backpressure: stall holds PC and IF/ID, flush_ex bubbles ID/EX. HAZ_PERF_CNT_EN adds stall counters.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MD_LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_fwd_unit_if.slave     hif
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_lu_stalls,
    output logic [31:0]          perf_md_stalls
`endif
);
    logic              md_busy;
    logic [REG_AW-1:0] md_rd;
    logic              md_wb_valid;

    md_scoreboard #(
        .REG_AW (REG_AW),
        .MD_LAT (MD_LAT)
    ) u_md_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .ex_md_start (hif.ex_md_start),
        .ex_rd       (hif.ex_rd),
        .wb_regwr    (hif.wb_regwr),
        .md_busy     (md_busy),
        .md_rd       (md_rd),
        .md_wb_valid (md_wb_valid)
    );

    assign hif.md_busy     = md_busy;
    assign hif.md_rd       = md_rd;
    assign hif.md_wb_valid = md_wb_valid;

    logic [NUM_SRC*2-1:0] fwd_sel;
    logic [NUM_SRC-1:0]   lu_hit;
    logic [NUM_SRC-1:0]   raw_hit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] ex_s;
        logic [REG_AW-1:0] id_s;
        logic              m_hit;
        logic              wb_hit;

        assign ex_s   = hif.ex_src[i*REG_AW +: REG_AW];
        assign id_s   = hif.id_src[i*REG_AW +: REG_AW];
        assign m_hit  = hif.m_regwr  && (hif.m_rd  != '0) && (hif.m_rd  == ex_s);
        assign wb_hit = hif.wb_regwr && (hif.wb_rd != '0) && (hif.wb_rd == ex_s);
        // The younger producer in M wins over WB.
        assign fwd_sel[2*i +: 2] = m_hit ? FWD_M : (wb_hit ? FWD_WB : FWD_RF);
        // ex_rd != 0 is checked once in the OR-tree, which excludes r0 here too.
        assign lu_hit[i]  = hif.id_src_used[i] && (id_s == hif.ex_rd);
        assign raw_hit[i] = hif.id_src_used[i] && (id_s != '0) && (id_s == md_rd);
    end

    logic lu_haz;
    logic md_haz;

    assign lu_haz = hif.ex_memrd && hif.ex_regwr && (hif.ex_rd != '0) && (|lu_hit);
    // md_rd is never r0 while busy, so the WAW compare needs no zero check.
    assign md_haz = md_busy && ((|raw_hit) || hif.id_md_op ||
                                (hif.id_regwr && (hif.id_rd == md_rd)));

    assign hif.ex_fwd_sel  = fwd_sel;
    assign hif.m_store_fwd = hif.wb_regwr && hif.m_memwr && (hif.wb_rd != '0) &&
                             (hif.wb_rd == hif.m_rb);
    assign hif.stall       = lu_haz || md_haz;
    assign hif.flush_ex    = lu_haz || md_haz;

`ifdef HAZ_PERF_CNT_EN
    // Saturating stall-cycle counters; mul/div count excludes cycles already charged to load-use.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stalls <= '0;
            perf_md_stalls <= '0;
        end else begin
            if (lu_haz && (perf_lu_stalls != 32'hFFFF_FFFF))
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (md_haz && !lu_haz && (perf_md_stalls != 32'hFFFF_FFFF))
                perf_md_stalls <= perf_md_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: forwarding, store forwarding, load-use and mul/div stalls.
// Latency: one step per clock; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_hazard_fwd_unit;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int MD_LAT  = 4;

    typedef struct {
        string       tag;
        logic [3:0]  sel;
        logic        store;
        logic        stall;
        logic        busy;
        logic [4:0]  mdrd;
        logic        wbv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) hif();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lu;
    logic [31:0] perf_md;
`endif

    hazard_fwd_unit #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .MD_LAT  (MD_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hif            (hif.slave)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_lu_stalls (perf_lu),
        .perf_md_stalls (perf_md)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        hif.id_src = '0;  hif.id_src_used = '0; hif.id_rd = '0; hif.id_regwr = 1'b0;
        hif.id_md_op = 1'b0; hif.ex_src = '0; hif.ex_rd = '0; hif.ex_regwr = 1'b0;
        hif.ex_memrd = 1'b0; hif.ex_md_start = 1'b0; hif.m_rd = '0; hif.m_regwr = 1'b0;
        hif.m_memwr = 1'b0; hif.m_rb = '0; hif.wb_rd = '0; hif.wb_regwr = 1'b0;
    endtask

    // Queue the expected outputs for the inputs just driven, then compare on the falling edge.
    task automatic step(input string tag, input logic [3:0] sel, input logic store,
                        input logic stall, input logic busy, input logic [4:0] mdrd,
                        input logic wbv);
        exp_t e;
        exp_t p;
        e.tag = tag; e.sel = sel; e.store = store; e.stall = stall;
        e.busy = busy; e.mdrd = mdrd; e.wbv = wbv;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            p = exp_q.pop_front();
            chk({p.tag, "_sel"},   32'(hif.ex_fwd_sel),  32'(p.sel));
            chk({p.tag, "_store"}, 32'(hif.m_store_fwd), 32'(p.store));
            chk({p.tag, "_stall"}, 32'(hif.stall),       32'(p.stall));
            chk({p.tag, "_flush"}, 32'(hif.flush_ex),    32'(p.stall));
            chk({p.tag, "_busy"},  32'(hif.md_busy),     32'(p.busy));
            chk({p.tag, "_mdrd"},  32'(hif.md_rd),       32'(p.mdrd));
            chk({p.tag, "_wbv"},   32'(hif.md_wb_valid), 32'(p.wbv));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic md_start(input logic [4:0] rd);
        clr();
        hif.ex_md_start = 1'b1; hif.ex_rd = rd; hif.ex_regwr = 1'b1;
        step("md_issue", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        clr();
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk); #1;
        step("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;

        // Operand forwarding priority and r0 exclusion.
        hif.m_regwr = 1'b1; hif.m_rd = 5'd7; hif.wb_regwr = 1'b1; hif.wb_rd = 5'd7;
        hif.ex_src = {5'd0, 5'd7};
        step("fwd_m_over_wb", 4'b0010, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        hif.m_regwr = 1'b0;
        step("fwd_wb", 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        hif.m_regwr = 1'b1; hif.m_rd = 5'd0;
        step("fwd_m_r0", 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        hif.m_rd = 5'd8; hif.ex_src = {5'd8, 5'd7};
        step("fwd_two_src", 4'b1001, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Store-data forwarding from WB.
        clr();
        hif.m_memwr = 1'b1; hif.m_rb = 5'd5; hif.wb_regwr = 1'b1; hif.wb_rd = 5'd5;
        step("store_fwd", 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        hif.wb_rd = 5'd0;
        step("store_fwd_r0", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Load-use: one stall, bubble, then the load is in WB and forwards to EX.
        clr();
        hif.ex_memrd = 1'b1; hif.ex_regwr = 1'b1; hif.ex_rd = 5'd3;
        hif.id_src = {5'd3, 5'd0}; hif.id_src_used = 2'b10;
        step("lu_stall", 4'b0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        clr();
        hif.m_regwr = 1'b1; hif.m_rd = 5'd3;
        hif.id_src = {5'd3, 5'd0}; hif.id_src_used = 2'b10;
        step("lu_bubble", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        clr();
        hif.wb_regwr = 1'b1; hif.wb_rd = 5'd3; hif.ex_src = {5'd3, 5'd0};
        step("lu_fwd_wb", 4'b0100, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        clr();
        hif.ex_memrd = 1'b1; hif.ex_regwr = 1'b1; hif.ex_rd = 5'd3;
        hif.id_src = {5'd3, 5'd0}; hif.id_src_used = 2'b01;
        step("lu_unused", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Mul/div RAW: stall through the writeback cycle t+4, release at t+5.
        md_start(5'd9);
        hif.id_src = {5'd0, 5'd9}; hif.id_src_used = 2'b01;
        for (int k = 1; k <= MD_LAT - 1; k++)
            step("md_raw", 4'b0000, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        step("md_raw_wb", 4'b0000, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1);
        step("md_raw_rel", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Deferred writeback while WB is occupied at t+4..t+5.
        md_start(5'd9);
        hif.id_src = {5'd0, 5'd9}; hif.id_src_used = 2'b01;
        for (int k = 1; k <= MD_LAT - 1; k++)
            step("md_def_cnt", 4'b0000, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        hif.wb_regwr = 1'b1; hif.wb_rd = 5'd4;
        step("md_def_hold", 4'b0000, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        step("md_def_hold", 4'b0000, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        hif.wb_regwr = 1'b0;
        step("md_def_wb", 4'b0000, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1);
        step("md_def_rel", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Structural and WAW stalls; a second start while busy is ignored.
        md_start(5'd9);
        hif.id_md_op = 1'b1;
        step("md_struct", 4'b0000, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        hif.id_md_op = 1'b0; hif.id_regwr = 1'b1; hif.id_rd = 5'd9;
        step("md_waw", 4'b0000, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        hif.id_rd = 5'd10; hif.ex_md_start = 1'b1; hif.ex_rd = 5'd12;
        step("md_waw_other", 4'b0000, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        clr();
        step("md_viol_ign", 4'b0000, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
        step("md_viol_done", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Reset mid-operation drops the result without a writeback.
        md_start(5'd9);
        step("md_rst_busy", 4'b0000, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        rst = 1'b1;
        step("md_rst_edge", 4'b0000, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++)
            step("md_rst_gone", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        // A start targeting r0 is not tracked.
        clr();
        hif.ex_md_start = 1'b1; hif.ex_rd = 5'd0;
        step("md_r0_issue", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        clr();
        step("md_r0_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
